// File: rtl/line_burst_adaptor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : line_burst_adaptor                                         |
// | Description : Bridges whole-line cache fills/writebacks to a beat-wise   |
// |               memory burst interface. A fill collects BEATS beats into   |
// |               line_o; a writeback streams the latched line out on        |
// |               burst_o. Each acknowledged beat advances a beat counter;   |
// |               after the last beat the cache gets a one-cycle resp_o.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module line_burst_adaptor #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               address_i,
  input  logic                      read_i,
  input  logic                      write_i,
  input  logic [BEAT_W*BEATS-1:0]   line_i,
  output logic [BEAT_W*BEATS-1:0]   line_o,
  output logic                      resp_o,
  output logic [31:0]               address_o,
  output logic                      read_o,
  output logic                      write_o,
  output logic [BEAT_W-1:0]         burst_o,
  input  logic [BEAT_W-1:0]         burst_i,
  input  logic                      resp_i
);

  localparam int c_cnt_w = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Lines are held beat-indexed so the counter selects a beat directly.
  state_t                          state_q, state_d;
  logic [c_cnt_w-1:0]              cnt_q, cnt_d;
  logic [31:0]                     addr_q, addr_d;
  logic [BEATS-1:0][BEAT_W-1:0]    wline_q, wline_d;
  logic [BEATS-1:0][BEAT_W-1:0]    line_q, line_d;
  logic                            resp_q, resp_d;
  logic                            read_q, read_d;
  logic                            write_q, write_d;
  logic [BEAT_W-1:0]               burst_q, burst_d;

  // Next-state, beat counter and datapath; outputs are decoded from the
  // next state so that they come straight out of flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    line_d  = line_q;

    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous read and write request resolves to the read.
        if (read_i) begin
          addr_d  = {address_i[31:5], 5'b0};
          cnt_d   = '0;
          state_d = ST_READ;
        end else if (write_i) begin
          addr_d  = {address_i[31:5], 5'b0};
          wline_d = line_i;
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end

      ST_READ: begin
        if (resp_i) begin
          line_d[cnt_q] = burst_i;
          if (cnt_q == c_last_beat) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (resp_i) begin
          if (cnt_q == c_last_beat) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Requests still held by the cache are not looked at here, which
      // guarantees an IDLE cycle before the next burst starts.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    read_d  = (state_d == ST_READ);
    write_d = (state_d == ST_WRITE);
    resp_d  = (state_d == ST_DONE);
    burst_d = wline_d[cnt_d];
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      line_q  <= '0;
      resp_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      line_q  <= line_d;
      resp_q  <= resp_d;
      read_q  <= read_d;
      write_q <= write_d;
      burst_q <= burst_d;
    end
  end

  assign line_o    = line_q;
  assign resp_o    = resp_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign burst_o   = burst_q;

endmodule
`default_nettype wire

// File: tb/tb_line_burst_adaptor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_line_burst_adaptor                                      |
// | Description : Self-checking bench for line_burst_adaptor: a table of     |
// |               request vectors, hand-written corner sequences and random  |
// |               transactions checked against a transaction-level model.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_line_burst_adaptor;

  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LW     = BEAT_W * BEATS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       address_i = '0;
  logic              read_i = 1'b0;
  logic              write_i = 1'b0;
  logic [LW-1:0]     line_i = '0;
  logic [LW-1:0]     line_o;
  logic              resp_o;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic [BEAT_W-1:0] burst_o;
  logic [BEAT_W-1:0] burst_i = '0;
  logic              resp_i = 1'b0;

  line_burst_adaptor #(.BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: the line the cache should see on line_o (last completed fill).
  logic [LW-1:0] model_line = '0;
  // Optional scripted acknowledge pattern; empty means random gaps.
  bit resp_pat[$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] exp_addr;
    bit          exp_rd;
    bit          exp_wr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [BEAT_W-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  // One complete cache transaction from an IDLE cycle through resp_o.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] exp_addr, input bit exp_rd, input bit exp_wr,
                         input logic [LW-1:0] wl, input logic [LW-1:0] rl,
                         input string tag, output int ncyc);
    int k;
    int cyc;
    bit r;
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = wl;
    resp_i    = 1'b0;
    chk({tag, ".idle_read_o"},  LW'(read_o),  '0);
    chk({tag, ".idle_write_o"}, LW'(write_o), '0);
    tick();
    // Scramble the request-time inputs to show they were latched.
    line_i    = ~wl;
    address_i = ~addr;
    chk({tag, ".address_o"}, LW'(address_o), LW'(exp_addr));
    k   = 0;
    cyc = 0;
    while (k < BEATS) begin
      if (cyc > 200) begin
        miscompares++;
        vectors++;
        $display("FAIL %s.timeout: got %0d beats expected %0d", tag, k, BEATS);
        break;
      end
      chk({tag, ".read_o"},  LW'(read_o),  LW'(exp_rd));
      chk({tag, ".write_o"}, LW'(write_o), LW'(exp_wr));
      chk({tag, ".resp_o_busy"}, LW'(resp_o), '0);
      if (exp_wr) chk({tag, ".burst_o"}, LW'(burst_o), LW'(wl[k*BEAT_W +: BEAT_W]));
      if (resp_pat.size() > 0) r = resp_pat.pop_front();
      else                     r = ($urandom_range(0, 2) != 0);
      resp_i  = r;
      burst_i = r ? rl[k*BEAT_W +: BEAT_W] : rand_beat();
      tick();
      if (r) k++;
      cyc++;
    end
    ncyc = cyc;
    if (exp_rd) model_line = rl;
    // Stray acknowledge during DONE must be ignored.
    resp_i  = $urandom_range(0, 1) != 0;
    burst_i = rand_beat();
    chk({tag, ".resp_o"},      LW'(resp_o),    1);
    chk({tag, ".done_read_o"}, LW'(read_o),    '0);
    chk({tag, ".done_write_o"},LW'(write_o),   '0);
    chk({tag, ".line_o"},      line_o,         model_line);
    chk({tag, ".done_addr"},   LW'(address_o), LW'(exp_addr));
    read_i  = 1'b0;
    write_i = 1'b0;
    tick();
    resp_i = 1'b0;
    chk({tag, ".resp_o_after"}, LW'(resp_o), '0);
    chk({tag, ".line_o_after"}, line_o,      model_line);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc;
    logic [LW-1:0] dline;
    logic [LW-1:0] aline;
    logic [31:0]   a;
    bit            rd;
    bit            wr;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEE0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'h8000_001F, 32'h8000_0000, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0020, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'h1357_9BDF, 32'h1357_9BC0, 1'b1, 1'b0};

    // Reset state, checked before any clock edge is released.
    #12;
    chk("rst.read_o",    LW'(read_o),    '0);
    chk("rst.write_o",   LW'(write_o),   '0);
    chk("rst.resp_o",    LW'(resp_o),    '0);
    chk("rst.address_o", LW'(address_o), '0);
    chk("rst.burst_o",   LW'(burst_o),   '0);
    chk("rst.line_o",    line_o,         '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Table-driven request vectors.
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].exp_addr, tbl[i].exp_rd,
              tbl[i].exp_wr, rand_line(), rand_line(), $sformatf("tbl%0d", i), ncyc);
    end

    // Read, no gaps: minimum latency and beat ordering.
    aline = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
             64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    for (int i = 0; i < BEATS; i++) resp_pat.push_back(1'b1);
    run_txn(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, 1'b1, 1'b0, '0, aline, "rd_nogap", ncyc);
    chk("rd_nogap.cycles", LW'(ncyc), LW'(BEATS));

    // Write with gaps: burst_o holds the current beat through stalls.
    dline = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
             64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    resp_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_txn(1'b0, 1'b1, 32'h0000_5678, 32'h0000_5660, 1'b0, 1'b1, dline, '0, "wr_gaps", ncyc);
    chk("wr_gaps.cycles", LW'(ncyc), 7);
    chk("wr_gaps.line_o", line_o, aline);

    // Reset in the middle of a read.
    read_i    = 1'b1;
    address_i = 32'h0000_4567;
    tick();
    resp_i  = 1'b1;
    burst_i = 64'h1111_1111_1111_1111;
    tick();
    burst_i = 64'h2222_2222_2222_2222;
    tick();
    resp_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_line = '0;
    chk("midrst.read_o",    LW'(read_o),    '0);
    chk("midrst.write_o",   LW'(write_o),   '0);
    chk("midrst.resp_o",    LW'(resp_o),    '0);
    chk("midrst.address_o", LW'(address_o), '0);
    chk("midrst.burst_o",   LW'(burst_o),   '0);
    chk("midrst.line_o",    line_o,         '0);
    read_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst.resp_o", LW'(resp_o), '0);
      chk("postrst.read_o", LW'(read_o), '0);
    end
    for (int i = 0; i < BEATS; i++) resp_pat.push_back(1'b1);
    run_txn(1'b1, 1'b0, 32'h0000_4567, 32'h0000_4560, 1'b1, 1'b0, '0, rand_line(),
            "rd_after_rst", ncyc);

    // Stray acknowledges in IDLE, then a write that must start at beat 0.
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = rand_beat();
      tick();
      chk("stray.line_o",  line_o,         model_line);
      chk("stray.resp_o",  LW'(resp_o),    '0);
      chk("stray.write_o", LW'(write_o),   '0);
    end
    resp_i = 1'b0;
    run_txn(1'b0, 1'b1, 32'h0000_9ABC, 32'h0000_9AA0, 1'b0, 1'b1, dline, '0, "stray_wr", ncyc);

    // Random transactions against the model.
    for (int t = 0; t < 40; t++) begin
      rd = $urandom_range(0, 1) != 0;
      wr = rd ? ($urandom_range(0, 1) != 0) : 1'b1;
      a  = $urandom;
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        resp_i  = $urandom_range(0, 1) != 0;
        burst_i = rand_beat();
        tick();
        chk("rnd.idle_line_o", line_o, model_line);
      end
      resp_i = 1'b0;
      run_txn(rd, wr, a, {a[31:5], 5'b0}, rd, !rd, rand_line(), rand_line(),
              $sformatf("rnd%0d", t), ncyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL provide parameter BEAT_W, default 64: memory-side beat width in bits.
REQ-002 SHALL provide parameter BEATS, default 4: beats per cache line; line width is BEAT_W*BEATS (256 by default).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 address_i  input  32  cache-side line address; low 5 bits are ignored.
REQ-007 read_i  input  1  cache requests a line fill; held until resp_o.
REQ-008 write_i  input  1  cache requests a line writeback; held until resp_o.
REQ-009 line_i  input  BEAT_W*BEATS  line to write back; sampled at request acceptance.
REQ-010 line_o  output  BEAT_W*BEATS  assembled fill line.
REQ-011 resp_o  output  1  single-cycle completion pulse to the cache.
REQ-012 address_o  output  32  memory burst address, {address_i[31:5], 5'b0}.
REQ-013 read_o  output  1  memory burst read request.
REQ-014 write_o  output  1  memory burst write request.
REQ-015 burst_o  output  BEAT_W  current write beat.
REQ-016 burst_i  input  BEAT_W  read beat from memory.
REQ-017 resp_i  input  1  memory beat acknowledge, one per beat.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WRITE and DONE, plus a beat counter of clog2(BEATS) bits.
REQ-019 IDLE: on a rising clk edge with read_i=1, SHALL latch the address, clear the counter and go to READ.
REQ-020 IDLE: on a rising clk edge with write_i=1 and read_i=0, SHALL latch the address and line_i, clear the counter and go to WRITE.
REQ-021 read_i and write_i both high in IDLE SHALL be treated as a read; write_i SHALL be ignored.
REQ-022 read_o SHALL equal 1 exactly while in READ, and write_o SHALL equal 1 exactly while in WRITE, both decoded from state with no combinational path from the inputs.
REQ-023 address_o SHALL hold the latched aligned address from acceptance until the next acceptance.
REQ-024 READ: each cycle with resp_i=1 SHALL store burst_i into line_o bits [BEAT_W*k +: BEAT_W], where k is the counter, and then increment k.
REQ-025 WRITE: burst_o SHALL present latched-line beat k; each cycle with resp_i=1 SHALL increment k.
REQ-026 Gaps (resp_i=0) between beats SHALL be allowed and SHALL stall the counter.
REQ-027 The beat with k=BEATS-1 and resp_i=1 SHALL move the FSM to DONE and wrap k to 0.
REQ-028 DONE SHALL assert resp_o for exactly one cycle, then return to IDLE; requests are not sampled in DONE.
REQ-029 line_o SHALL hold its value from the end of a fill until the next fill overwrites it; writes SHALL NOT modify line_o.
REQ-030 resp_i while in IDLE or DONE SHALL be ignored, with no state, counter or line_o change.
REQ-031 Minimum latency SHALL be: acceptance edge at cycle 0, beats at cycles 1..BEATS, resp_o at cycle BEATS+1.
REQ-032 Back-to-back requests SHALL leave at least one IDLE cycle between resp_o and the next read_o or write_o.

Reset
REQ-033 rst=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and the counter to 0.
REQ-034 rst=0 SHALL immediately force resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0 and line_o=0.
REQ-035 Reset asserted mid-burst SHALL abandon the transfer with no resp_o pulse, and after release the block SHALL accept a new request normally.

Verification
REQ-036 Read, no gaps: read_i=1, address_i=0x0000_1234, resp_i=1 with beats 0xA0..,0xA1..,0xA2..,0xA3.. -> address_o=0x0000_1220; read_o high for cycles 1-4; resp_o at cycle 5; line_o = {A3,A2,A1,A0}.
REQ-037 Write with gaps: write_i=1, line_i = {D3,D2,D1,D0}, resp_i pattern 1,0,1,0,0,1,1 -> burst_o goes D0,D1,D1,D2,D2,D2,D3; write_o falls after the 4th acknowledge; resp_o pulses once; line_o unchanged.
REQ-038 Simultaneous read_i and write_i in IDLE -> read_o=1, write_o stays 0, and a full fill completes.
REQ-039 Reset mid-read (rst=0 after 2 beats, released, then a new read) -> all outputs 0 during reset; the new read fills all 4 beats from beat 0 and gives a single resp_o.
REQ-040 Stray resp_i=1 in IDLE, then a write -> no counter advance; the write's first beat is D0.
